// File: rtl/count_seq_mon_pkg.sv
// count_seq_mon_pkg: shared types and helpers for count_seq_monitor.
// Provides the FSM state enum, the default relock length and next_count().
package count_seq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam int RELOCK_N_DEF = 2;

    // Successor of a 2-bit counter value, wrapping 3 -> 0.
    function automatic logic [1:0] next_count(input logic [1:0] v);
        return v + 2'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that holds at all-ones; clr beats inc.
// Ports: clk, rst (sync, active-high), inc, clr, q[W-1:0].
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks a 2-bit counter follows 0->1->2->3->0, counts
// wraps while locked, counts/flags illegal steps and relocks after
// RELOCK_N consecutive legal steps.
// Ports: clk, rst (sync, active-high), count_in[1:0], clear,
//        wraps[WRAP_W-1:0], err_cnt[ERR_W-1:0], err_pulse, seq_err, locked.
// Macro COUNT_SEQ_MON_HOLD_EN: when defined, count_in == prev is neutral.
module count_seq_monitor
    import count_seq_mon_pkg::*;
#(
    parameter int WRAP_W   = 4,
    parameter int ERR_W    = 4,
    parameter int RELOCK_N = RELOCK_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        count_in,
    input  logic              clear,
    output logic [WRAP_W-1:0] wraps,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_pulse,
    output logic              seq_err,
    output logic              locked
);

    localparam logic [2:0] RELOCK_V = 3'(RELOCK_N);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_prev;
    logic [2:0]        r_run;
    logic [2:0]        w_run_nxt;
    logic [2:0]        w_run_inc;
    logic [WRAP_W-1:0] r_wraps;
    logic              r_err_pulse;
    logic              r_seq_err;
    logic              r_locked;
    logic              w_legal;
    logic              w_hold;
    logic              w_bad;
    logic              w_err;
    logic              w_wrap;

    assign w_legal   = (count_in == next_count(r_prev));
    assign w_run_inc = r_run + 3'd1;

`ifdef COUNT_SEQ_MON_HOLD_EN
    // A holding counter neither errs nor advances the relock run.
    assign w_hold = (count_in == r_prev);
`else
    assign w_hold = 1'b0;
`endif

    assign w_bad = ~w_legal & ~w_hold;

    always_comb begin
        w_next    = r_state;
        w_run_nxt = r_run;
        w_err     = 1'b0;
        w_wrap    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_next = LOCKED;
            end
            LOCKED: begin
                if (w_bad) begin
                    w_err     = 1'b1;
                    w_next    = RESYNC;
                    w_run_nxt = 3'd0;
                end else if (w_legal && (r_prev == 2'd3)) begin
                    w_wrap = 1'b1;
                end
            end
            RESYNC: begin
                if (w_bad) begin
                    w_err     = 1'b1;
                    w_run_nxt = 3'd0;
                end else if (w_legal) begin
                    if (w_run_inc == RELOCK_V) begin
                        w_next    = LOCKED;
                        w_run_nxt = 3'd0;
                    end else begin
                        w_run_nxt = w_run_inc;
                    end
                end
            end
            default: begin
                w_next    = IDLE;
                w_run_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prev      <= 2'd0;
            r_run       <= 3'd0;
            r_wraps     <= '0;
            r_err_pulse <= 1'b0;
            r_seq_err   <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_prev      <= count_in;
            r_run       <= w_run_nxt;
            r_err_pulse <= w_err;
            // Registered decode so locked always mirrors the state register.
            r_locked    <= (w_next == LOCKED);
            if (clear) begin
                r_wraps   <= '0;
                r_seq_err <= 1'b0;
            end else begin
                if (w_wrap) begin
                    r_wraps <= r_wraps + {{(WRAP_W-1){1'b0}}, 1'b1};
                end
                if (w_err) begin
                    r_seq_err <= 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk(clk),
        .rst(rst),
        .inc(w_err),
        .clr(clear),
        .q  (err_cnt)
    );

    assign wraps     = r_wraps;
    assign err_pulse = r_err_pulse;
    assign seq_err   = r_seq_err;
    assign locked    = r_locked;

endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor: directed self-checking bench for count_seq_monitor.
// Scenario tasks run in sequence; summary line printed at the end.
module tb_count_seq_monitor;

    logic       clk;
    logic       rst;
    logic [1:0] count_in;
    logic       clear;
    logic [3:0] wraps;
    logic [3:0] err_cnt;
    logic       err_pulse;
    logic       seq_err;
    logic       locked;

    int checks;
    int failures;

    count_seq_monitor #(
        .WRAP_W  (4),
        .ERR_W   (4),
        .RELOCK_N(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .clear    (clear),
        .wraps    (wraps),
        .err_cnt  (err_cnt),
        .err_pulse(err_pulse),
        .seq_err  (seq_err),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [1:0] v, input logic c);
        count_in = v;
        clear    = c;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        clear    = 1'b0;
        count_in = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wraps, err_cnt, err_pulse, seq_err, locked} !== 11'd0) begin
            failures++;
            $display("FAIL reset outs got=%b exp=0",
                     {wraps, err_cnt, err_pulse, seq_err, locked});
        end
        rst = 1'b0;
    endtask

    task automatic test_lock_and_wrap;
        logic [1:0] seq [9];
        int pulses;
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step(seq[i], 1'b0);
            if (err_pulse) pulses++;
            if (i == 1) begin
                checks++;
                if (locked !== 1'b1) begin
                    failures++;
                    $display("FAIL lock_early got=%b exp=1", locked);
                end
            end
            if (i == 4) begin
                checks++;
                if (wraps !== 4'd1) begin
                    failures++;
                    $display("FAIL first_wrap got=%0d exp=1", wraps);
                end
            end
        end
        checks++;
        if (wraps !== 4'd2) begin
            failures++;
            $display("FAIL wraps_two got=%0d exp=2", wraps);
        end
        checks++;
        if ({pulses[3:0], err_cnt, seq_err} !== 9'd0) begin
            failures++;
            $display("FAIL clean_run pulses=%0d err_cnt=%0d seq_err=%b exp=0",
                     pulses, err_cnt, seq_err);
        end
    endtask

    task automatic test_error_resync;
        step(2'd1, 1'b0);
        step(2'd3, 1'b0);
        checks++;
        if ({err_pulse, err_cnt, seq_err, locked} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL inject got pulse=%b cnt=%0d seq=%b lock=%b exp 1,1,1,0",
                     err_pulse, err_cnt, seq_err, locked);
        end
        step(2'd0, 1'b0);
        checks++;
        if ({err_pulse, locked, wraps} !== {1'b0, 1'b0, 4'd2}) begin
            failures++;
            $display("FAIL resync_run1 got pulse=%b lock=%b wraps=%0d exp 0,0,2",
                     err_pulse, locked, wraps);
        end
        step(2'd1, 1'b0);
        checks++;
        if ({locked, wraps, err_cnt} !== {1'b1, 4'd2, 4'd1}) begin
            failures++;
            $display("FAIL relock got lock=%b wraps=%0d cnt=%0d exp 1,2,1",
                     locked, wraps, err_cnt);
        end
    endtask

    task automatic test_saturate;
        int pulses;
        step(2'd2, 1'b1);
        checks++;
        if ({err_cnt, seq_err, wraps} !== 9'd0) begin
            failures++;
            $display("FAIL clear_stats got cnt=%0d seq=%b wraps=%0d exp 0",
                     err_cnt, seq_err, wraps);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step((i % 2 == 0) ? 2'd0 : 2'd2, 1'b0);
            if (err_pulse) pulses++;
            if (i == 14) begin
                checks++;
                if (err_cnt !== 4'd15) begin
                    failures++;
                    $display("FAIL cnt_at_15 got=%0d exp=15", err_cnt);
                end
            end
        end
        checks++;
        if (err_cnt !== 4'd15) begin
            failures++;
            $display("FAIL cnt_sat got=%0d exp=15", err_cnt);
        end
        checks++;
        if (pulses !== 20) begin
            failures++;
            $display("FAIL pulse_count got=%0d exp=20", pulses);
        end
        step(2'd3, 1'b0);
        step(2'd0, 1'b0);
        checks++;
        if ({err_pulse, locked} !== 2'b01) begin
            failures++;
            $display("FAIL sat_relock got pulse=%b lock=%b exp 0,1",
                     err_pulse, locked);
        end
    endtask

    task automatic test_wrap_rollover_clear;
        step(2'd1, 1'b1);
        for (int g = 0; g < 17; g++) begin
            step(2'd2, 1'b0);
            step(2'd3, 1'b0);
            step(2'd0, 1'b0);
            step(2'd1, 1'b0);
            if (g == 15) begin
                checks++;
                if (wraps !== 4'd0) begin
                    failures++;
                    $display("FAIL wraps_roll got=%0d exp=0", wraps);
                end
            end
        end
        checks++;
        if (wraps !== 4'd1) begin
            failures++;
            $display("FAIL wraps_17 got=%0d exp=1", wraps);
        end
        step(2'd3, 1'b0);
        step(2'd0, 1'b0);
        step(2'd1, 1'b0);
        step(2'd2, 1'b0);
        step(2'd3, 1'b0);
        step(2'd0, 1'b1);
        checks++;
        if ({wraps, seq_err, err_cnt, locked} !== {4'd0, 1'b0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL clear_on_wrap got wraps=%0d seq=%b cnt=%0d lock=%b exp 0,0,0,1",
                     wraps, seq_err, err_cnt, locked);
        end
        step(2'd2, 1'b1);
        checks++;
        if ({err_pulse, err_cnt, seq_err, locked} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clear_on_err got pulse=%b cnt=%0d seq=%b lock=%b exp 1,0,0,0",
                     err_pulse, err_cnt, seq_err, locked);
        end
    endtask

    task automatic test_hold;
        step(2'd3, 1'b0);
        step(2'd0, 1'b0);
        checks++;
        if ({locked, wraps} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL resync_no_wrap got lock=%b wraps=%0d exp 1,0",
                     locked, wraps);
        end
        step(2'd1, 1'b0);
        step(2'd2, 1'b0);
        step(2'd2, 1'b0);
        checks++;
`ifdef COUNT_SEQ_MON_HOLD_EN
        if ({err_pulse, locked, err_cnt} !== {1'b0, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL hold_neutral got pulse=%b lock=%b cnt=%0d exp 0,1,0",
                     err_pulse, locked, err_cnt);
        end
`else
        if ({err_pulse, locked, err_cnt} !== {1'b1, 1'b0, 4'd1}) begin
            failures++;
            $display("FAIL hold_illegal got pulse=%b lock=%b cnt=%0d exp 1,0,1",
                     err_pulse, locked, err_cnt);
        end
`endif
    endtask

    task automatic test_rst_mid;
        step(2'd0, 1'b0);
        step(2'd1, 1'b0);
        checks++;
        if ({locked, seq_err} !== 2'b01) begin
            failures++;
            $display("FAIL in_resync got lock=%b seq=%b exp 0,1", locked, seq_err);
        end
        rst      = 1'b1;
        clear    = 1'b1;
        count_in = 2'd3;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        clear = 1'b0;
        checks++;
        if ({wraps, err_cnt, err_pulse, seq_err, locked} !== 11'd0) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=0",
                     {wraps, err_cnt, err_pulse, seq_err, locked});
        end
        step(2'd3, 1'b0);
        checks++;
        if ({err_pulse, seq_err, locked} !== 3'b001) begin
            failures++;
            $display("FAIL first_sample got pulse=%b seq=%b lock=%b exp 0,0,1",
                     err_pulse, seq_err, locked);
        end
        step(2'd0, 1'b0);
        checks++;
        if ({err_pulse, wraps} !== {1'b0, 4'd1}) begin
            failures++;
            $display("FAIL post_reset_wrap got pulse=%b wraps=%0d exp 0,1",
                     err_pulse, wraps);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear    = 1'b0;
        count_in = 2'd0;
        test_reset();
        test_lock_and_wrap();
        test_error_resync();
        test_saturate();
        test_wrap_rollover_clear();
        test_hold();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
